// File: rtl/eu_iqueue.sv
// eu_iqueue: per-execution-unit instruction queue.
// Circular FIFO of type_iqueue_entry between dispatch/rename and one EU,
// presenting the oldest entry on a valid/ready handshake in program order,
// with a synchronous flush for pipeline squash.
// Optional feature: define EU_IQUEUE_BYPASS_EN to let an empty queue pass an
// incoming instruction straight through to the EU in the same cycle.

package eu_iqueue_pkg;

    typedef struct packed {
        logic [7:0]  tag;
        logic [3:0]  opcode;
        logic [15:0] payload;
    } type_iqueue_entry;

endpackage

module eu_iqueue
    import eu_iqueue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  type_iqueue_entry         enq_instr_i,
    input  logic                     enq_valid_i,
    output logic                     enq_ready_o,
    output type_iqueue_entry         dispatched_instr_o,
    output logic                     dispatched_instr_valid_o,
    input  logic                     eu_ready_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    type_iqueue_entry mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic empty;
    logic full;
    logic enq_fire;
    logic deq_fire;
    logic write_en;
    logic pop_en;

    // Separate occupancy counter keeps full and empty unambiguous when the
    // pointers are equal.
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    assign empty_o = empty;
    assign full_o  = full;
    assign count_o = count;

    // Ready depends only on registered occupancy: a dispatch in the same
    // cycle does not open a slot until the next cycle.
    assign enq_ready_o = !full;

`ifdef EU_IQUEUE_BYPASS_EN
    // An empty queue forwards the incoming instruction combinationally.
    assign dispatched_instr_valid_o = (!empty || enq_valid_i) && !flush_i;
    assign dispatched_instr_o       = empty ? enq_instr_i : mem[rd_ptr];
`else
    assign dispatched_instr_valid_o = !empty && !flush_i;
    assign dispatched_instr_o       = mem[rd_ptr];
`endif

    assign enq_fire = enq_valid_i && !full && !flush_i;
    assign deq_fire = dispatched_instr_valid_o && eu_ready_i;

    // Only a dispatch out of storage advances the read side; a bypassed
    // entry never touched the array.
    assign pop_en = deq_fire && !empty;

`ifdef EU_IQUEUE_BYPASS_EN
    // An entry the EU takes straight through is not written.
    assign write_en = enq_fire && !(empty && deq_fire);
`else
    assign write_en = enq_fire;
`endif

    // Next occupancy: flush clears, simultaneous push and pop cancel out.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        count_next = count;
        if (flush_i) begin
            count_next = '0;
        end else begin
            case ({write_en, pop_en})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    // Pointer and occupancy registers; flush and reset both return to origin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (write_en) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_en)   rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; occupancy alone decides which slots are meaningful.
        if (write_en) mem[wr_ptr] <= enq_instr_i;
    end

endmodule

// File: tb/tb_eu_iqueue.sv
// Self-checking bench for eu_iqueue (DEPTH = 8): a directed vector table
// for fill/drain and full-plus-dispatch, then hand-written sequences for
// pointer wrap, flush, bypass behaviour and asynchronous reset.

module tb_eu_iqueue;
    import eu_iqueue_pkg::*;

`ifdef EU_IQUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    type_iqueue_entry enq_instr;
    logic             enq_valid;
    logic             enq_ready;
    type_iqueue_entry disp_instr;
    logic             disp_valid;
    logic             eu_ready;
    logic             flush;
    logic [3:0]       count;
    logic             full;
    logic             empty;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       enq_valid;
        logic [7:0] tag;
        logic       eu_ready;
        logic       flush;
        logic       exp_valid;
        logic [7:0] exp_tag;
        logic [3:0] exp_count;
        string      name;
    } vec_t;

    eu_iqueue #(.DEPTH(8)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .enq_instr_i              (enq_instr),
        .enq_valid_i              (enq_valid),
        .enq_ready_o              (enq_ready),
        .dispatched_instr_o       (disp_instr),
        .dispatched_instr_valid_o (disp_valid),
        .eu_ready_i               (eu_ready),
        .flush_i                  (flush),
        .count_o                  (count),
        .full_o                   (full),
        .empty_o                  (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic type_iqueue_entry make_entry(input logic [7:0] t);
        type_iqueue_entry e;
        e.tag     = t;
        e.opcode  = t[3:0] ^ 4'h5;
        e.payload = {t, ~t};
        return e;
    endfunction

    function automatic vec_t mk(input logic ev, input logic [7:0] tg, input logic er,
                                input logic fl, input logic xv, input logic [7:0] xt,
                                input logic [3:0] xc, input string nm);
        vec_t v;
        v.enq_valid = ev;
        v.tag       = tg;
        v.eu_ready  = er;
        v.flush     = fl;
        v.exp_valid = xv;
        v.exp_tag   = xt;
        v.exp_count = xc;
        v.name      = nm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check pre-edge outputs mid-cycle, then
    // advance past the next rising edge.
    task automatic run_vec(input vec_t v);
        enq_valid = v.enq_valid;
        enq_instr = make_entry(v.tag);
        eu_ready  = v.eu_ready;
        flush     = v.flush;
        #2;
        check({v.name, ".valid"}, 32'(disp_valid), 32'(v.exp_valid));
        if (v.exp_valid)
            check({v.name, ".instr"}, 32'(disp_instr), 32'(make_entry(v.exp_tag)));
        check({v.name, ".count"}, 32'(count), 32'(v.exp_count));
        check({v.name, ".full"},  32'(full),  32'(v.exp_count == 4'd8));
        check({v.name, ".empty"}, 32'(empty), 32'(v.exp_count == 4'd0));
        check({v.name, ".ready"}, 32'(enq_ready), 32'(v.exp_count != 4'd8));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [19];

    initial begin
        // Fill with tags 0..7 while the EU stalls; tag 8 is held off when full.
        for (int k = 0; k < 8; k++)
            tbl[k] = mk(1'b1, 8'(k), 1'b0, 1'b0, (k > 0) || BYP, 8'h00, 4'(k), "fill");
        tbl[8]  = mk(1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 8'h00, 4'd8, "full_hold");
        // Full plus dispatch: enqueue refused, count drops to 7.
        tbl[9]  = mk(1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 8'h00, 4'd8, "full_disp");
        // Ready again: tag 8 accepted alongside the dispatch of tag 1.
        tbl[10] = mk(1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 8'h01, 4'd7, "refill");
        for (int k = 0; k < 7; k++)
            tbl[11 + k] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(k + 2), 4'(7 - k), "drain");
        tbl[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, "drained");

        reset_n   = 1'b0;
        enq_valid = 1'b0;
        enq_instr = make_entry(8'h00);
        eu_ready  = 1'b0;
        flush     = 1'b0;
        #11;
        check("reset.count", 32'(count), 32'd0);
        check("reset.empty", 32'(empty), 32'd1);
        check("reset.full",  32'(full),  32'd0);
        check("reset.ready", 32'(enq_ready), 32'd1);
        check("reset.valid", 32'(disp_valid), 32'd0);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) run_vec(tbl[i]);

        // Wrap-around: steady occupancy 3 with one in, one out per cycle.
        run_vec(mk(1'b1, 8'h20, 1'b0, 1'b0, BYP,  8'h20, 4'd0, "wrap_pre0"));
        run_vec(mk(1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 8'h20, 4'd1, "wrap_pre1"));
        run_vec(mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h20, 4'd2, "wrap_pre2"));
        for (int i = 0; i < 20; i++)
            run_vec(mk(1'b1, 8'(8'h23 + i), 1'b1, 1'b0, 1'b1, 8'(8'h20 + i), 4'd3, "wrap"));
        for (int i = 0; i < 3; i++)
            run_vec(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(8'h34 + i), 4'(3 - i), "wrap_drain"));
        run_vec(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, "wrap_done"));

        // Flush at count 4 with a concurrent enqueue and EU ready.
        run_vec(mk(1'b1, 8'h40, 1'b0, 1'b0, BYP,  8'h40, 4'd0, "fl_pre"));
        for (int i = 1; i < 4; i++)
            run_vec(mk(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1, 8'h40, 4'(i), "fl_pre"));
        run_vec(mk(1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h00, 4'd4, "flush"));
        run_vec(mk(1'b1, 8'h0A, 1'b0, 1'b0, BYP,  8'h0A, 4'd0, "fl_after"));
        run_vec(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0A, 4'd1, "fl_first"));
        run_vec(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, "fl_done"));

        // Empty queue, enqueue tag 3 with the EU ready.
        run_vec(mk(1'b1, 8'h03, 1'b1, 1'b0, BYP, 8'h03, 4'd0, "byp"));
`ifdef EU_IQUEUE_BYPASS_EN
        run_vec(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, "byp_consumed"));
`else
        run_vec(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 4'd1, "byp_next"));
        run_vec(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, "byp_done"));
`endif

        // Asynchronous reset mid-stream at count 5.
        run_vec(mk(1'b1, 8'h50, 1'b0, 1'b0, BYP,  8'h50, 4'd0, "rst_fill"));
        for (int i = 1; i < 5; i++)
            run_vec(mk(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b1, 8'h50, 4'(i), "rst_fill"));
        enq_valid = 1'b0;
        #2;
        check("rst_mid.count_before", 32'(count), 32'd5);
        reset_n = 1'b0;
        #1;
        check("rst_mid.count", 32'(count), 32'd0);
        check("rst_mid.empty", 32'(empty), 32'd1);
        check("rst_mid.ready", 32'(enq_ready), 32'd1);
        check("rst_mid.valid", 32'(disp_valid), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        run_vec(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, "rst_after"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/eu_iqueue.md
# eu_iqueue

Per-execution-unit instruction queue sitting directly upstream of the execution unit. It buffers `type_iqueue_entry` instructions from the dispatch/rename stage in a circular FIFO and presents the oldest entry on the execution unit's `dispatched_instr_i` / `dispatched_instr_valid_i` / `ready_for_next_instr_o` handshake, in strict program order. It also supports a synchronous flush for pipeline squash.

## Interface

**Parameters**
- `DEPTH`, default 8: number of entries. Must be a power of two, ≥ 2.

**Ports**
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `enq_instr_i`  in  `$bits(type_iqueue_entry)`: instruction from the upstream stage.
- `enq_valid_i`  in  1: `enq_instr_i` is valid.
- `enq_ready_o`  out  1: queue can accept an entry this cycle.
- `dispatched_instr_o`  out  `$bits(type_iqueue_entry)`: oldest entry, driven to the EU.
- `dispatched_instr_valid_o`  out  1: `dispatched_instr_o` is valid.
- `eu_ready_i`  in  1: EU `ready_for_next_instr_o`.
- `flush_i`  in  1: discard all entries.
- `count_o`  out  `$clog2(DEPTH)+1`: current occupancy.
- `full_o`  out  1: `count_o == DEPTH`.
- `empty_o`  out  1: `count_o == 0`.

## Operation

- Storage: `DEPTH` × `type_iqueue_entry` register array, plus `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits.
  - Both pointers wrap naturally modulo `DEPTH`.
  - `count` is a separate register, so full and empty are never ambiguous.
- Enqueue fires when `enq_valid_i && enq_ready_o && !flush_i`: write `enq_instr_i` at `wr_ptr`, then `wr_ptr++`.
- `enq_ready_o = !full_o`. It is registered-state only and has no combinational path from `eu_ready_i`.
  - When full, an enqueue is refused even if a dispatch happens in the same cycle.
- Dispatch fires when `dispatched_instr_valid_o && eu_ready_i`: `rd_ptr++`.
- `dispatched_instr_o` is a combinational read of `mem[rd_ptr]`.
- `dispatched_instr_valid_o = !empty_o && !flush_i`.
- Count update:
  - enqueue only: +1
  - dispatch only: −1
  - both in the same cycle: unchanged
- Flush:
  - In the cycle `flush_i` is high, `dispatched_instr_valid_o` is forced low, so no dispatch occurs.
  - On the next edge: `rd_ptr = wr_ptr = 0`, `count = 0`.
  - A concurrent enqueue is dropped.
  - Array contents are not cleared.
- While `dispatched_instr_valid_o` is high and `eu_ready_i` is low, `dispatched_instr_o` stays stable until the transfer completes or a flush occurs.
- The queue never reorders, duplicates or drops entries, except on flush.

## Timing

- Reset (asynchronous, `reset_n` low):
  - Pointers and count go to 0.
  - `empty_o = 1`, `full_o = 0`, `enq_ready_o = 1`, `dispatched_instr_valid_o = 0`, `count_o = 0`.
  - `dispatched_instr_o` is don't-care.
  - A reset mid-operation discards all entries immediately.
- Latency, enqueue to earliest dispatch: 1 cycle (entry visible the cycle after the write edge). `eu_iqueue_bypass` is the exception; see Configuration.
- Throughput: 1 enqueue and 1 dispatch per cycle sustained, at any occupancy from 1 to `DEPTH−1`.
- Boundary cases:
  - **Full:** `enq_ready_o = 0`; a dispatch in that cycle frees a slot, and `enq_ready_o` is high from the next cycle.
  - **Empty:** `dispatched_instr_valid_o = 0`; an enqueue makes `count_o = 1` next cycle.
  - **Flush concurrent with enqueue and `eu_ready_i`:** the flush wins; `count_o = 0` next cycle.

## Configuration

- Macro: `EU_IQUEUE_BYPASS_EN`.
- When defined, an empty queue passes an incoming instruction straight through in the same cycle:
  - `dispatched_instr_valid_o = (!empty_o || enq_valid_i) && !flush_i`.
  - `dispatched_instr_o = empty_o ? enq_instr_i : mem[rd_ptr]`.
  - If empty and `eu_ready_i` is high, the entry is consumed directly: no write, and count stays 0.
  - If empty and `eu_ready_i` is low, the entry is written normally.
  - Zero-cycle latency; this adds a combinational path from `enq_*` to the EU.
- When undefined: behaviour is exactly as in Operation, with a 1-cycle minimum latency and all outputs derived from registered state plus `flush_i`.

## Test plan

- **Reset:** assert `reset_n = 0` mid-stream with `count_o = 5` -> immediately `count_o = 0`, `empty_o = 1`, `enq_ready_o = 1`, `dispatched_instr_valid_o = 0`.
- **Fill/drain:** with `DEPTH = 8`, hold `eu_ready_i = 0` and enqueue tags 0..8.
  - Expect tags 0..7 accepted, `full_o = 1`, `enq_ready_o = 0`, tag 8 held off.
  - Then raise `eu_ready_i` -> tags 0..8 dispatched in order, `empty_o = 1` at the end.
- **Wrap-around:** 20 cycles of simultaneous enqueue and dispatch at `count_o = 3` -> `count_o` constant at 3, output order identical to input order across pointer wrap.
- **Full plus dispatch:** at `count_o = 8`, assert enqueue and `eu_ready_i` together -> enqueue refused, `count_o = 7`; the following cycle's enqueue is accepted.
- **Flush:** at `count_o = 4`, assert `flush_i` with `enq_valid_i = 1` and `eu_ready_i = 1`.
  - Expect `dispatched_instr_valid_o = 0` in that cycle and `count_o = 0` next cycle.
  - The next enqueue of tag 0xA is dispatched as the first entry.
- **Bypass (`EU_IQUEUE_BYPASS_EN` defined):** empty queue, `enq_valid_i = 1` with tag 0x3, `eu_ready_i = 1` -> same-cycle `dispatched_instr_valid_o = 1` showing tag 0x3, and `count_o` stays 0.
  - Without the macro, the same stimulus gives `valid = 0` that cycle, then tag 0x3 the next cycle.
